dec38_pipe: RTL and testbench
=============================

# dec38_pipe

Registered 3-to-8 decoder with ready/valid on both sides; the receive-side counterpart of the 8:3 priority encoder. It takes encoded request indices plus a no-request flag, buffers up to two of them, and presents a one-hot 8-bit vector downstream. It also keeps a sticky mask of every line decoded so far and a wrapping count of delivered words, so a bench or host can reconcile traffic against what the encoder sent.

## Interface
- DEPTH, 2, buffer entries; only 2 is supported.
- CODE_W, 3, encoded index width; fixed, with the one-hot width = 2**CODE_W = 8.
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  upstream word present.
- in_ready  output  1  block can accept this cycle.
- in_code  input  3  encoded index 0..7.
- in_none  input  1  1 = encoder saw no request; decoded output is all zeros.
- out_valid  output  1  decoded word present.
- out_ready  input  1  downstream accepts.
- out_onehot  output  8  `1 << code`, or 8'h00 when none.
- seen  output  8  sticky OR of all delivered one-hot words.
- seen_clr  input  1  synchronous clear of `seen`.
- pop_cnt  output  8  count of delivered words, wraps 255 -> 0.

## Operation
- Push: a push occurs when `in_valid && in_ready`. The pair {in_none, in_code} is written to the tail of the 2-entry FIFO.
- Pop: a pop occurs when `out_valid && out_ready`. The head entry is removed.
- `in_ready = !full`. There is no pass-through when full: a push and pop in the same cycle while full is impossible, because in_ready is 0.
- Simultaneous push and pop with occupancy 1: occupancy stays 1, and the new entry becomes the head on the next cycle.
- `out_valid = !empty`. `out_onehot` is decoded from the head entry, with the register output held stable while `out_valid && !out_ready`.
- When `out_valid = 0`, `out_onehot` = 8'h00.
- `in_none = 1` takes precedence over `in_code`: the output is 8'h00 regardless of `in_code`. Such a word still pops and still increments pop_cnt.
- seen update:
  - On a pop without clear: `seen <= seen | out_onehot`.
  - With `seen_clr` and no pop: `seen <= 0`.
  - With `seen_clr` and a pop in the same cycle: `seen <= out_onehot`. Clear applies first, then the current pop sets its bit.
- pop_cnt: increments by 1 on every pop; modulo-256 wrap.
- Reset, asserted asynchronously at any time including mid-transfer:
  - FIFO is emptied and buffered entries are discarded.
  - `out_valid = 0`, `out_onehot = 0`, `seen = 0`, `pop_cnt = 0`.
  - `in_ready = 1` throughout reset and after release.

## Timing
- Latency: a push on edge N gives `out_valid = 1` with that word after edge N (visible in cycle N+1) if the FIFO was empty.
- Throughput: one word per cycle with `out_ready` held at 1.
- Fill: with `out_ready = 0`, in_ready drops after two pushes and rises the cycle after the first pop.
- All outputs are registered or derived only from registered state. There is no combinational path from in_valid/in_code to out_*, and none from out_ready to in_ready.

## Structure
- Package `dec38_pkg`:
  - `CODE_W`, `ONEHOT_W`.
  - Typedef `dec38_entry_t` = {none, code[2:0]}.
  - Function `dec38_onehot(entry)` returning 8 bits.
- Sub-module `dec38_fifo2`: the 2-entry storage with full/empty flags and read/write pointers.
- `dec38_pipe` contains the FIFO, the decode, the `seen` register and `pop_cnt`.

## Test plan
- Reset, then sweep codes 0..7 with `in_none = 0` and `out_ready = 1`. Required: out_onehot = 01, 02, 04 … 80, each one cycle after its push; pop_cnt = 8; seen = FF.
- Push {none = 1, code = 5}. Required: out_onehot = 00, out_valid = 1, seen unchanged, pop_cnt +1.
- Hold out_ready = 0, then push codes 3, 6, 1. Required: in_ready = 0 after the second push and code 1 is not accepted. Releasing out_ready delivers 08 then 40.
- With seen = 0x0F, pop code 7 in the same cycle as seen_clr = 1. Required: seen = 0x80.
- Make 256 pops. Required: pop_cnt returns to 0.
- Assert rst_n low mid-stream with 2 entries buffered. Required: out_valid, out_onehot, seen and pop_cnt are 0 immediately (asynchronously), and in_ready = 1.

Source files
------------

// File: rtl/dec38_pkg.sv
// Shared types and helpers for the registered 3-to-8 decoder.
//   CODE_W        encoded index width
//   ONEHOT_W      decoded one-hot width (2**CODE_W)
//   dec38_entry_t buffered word: {none, code}
//   dec38_onehot  decode of one buffered word; 'none' forces all zeros
package dec38_pkg;

  localparam int unsigned CODE_W   = 3;
  localparam int unsigned ONEHOT_W = 1 << CODE_W;

  typedef struct packed {
    logic              none;
    logic [CODE_W-1:0] code;
  } dec38_entry_t;

  function automatic logic [ONEHOT_W-1:0] dec38_onehot(input dec38_entry_t entry);
    logic [ONEHOT_W-1:0] vec;
    vec = '0;
    if (!entry.none) vec[entry.code] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/dec38_fifo2.sv
// Two-entry synchronous FIFO holding encoded decoder words.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   push, wdata write request and data (ignored while full)
//   pop         read request (ignored while empty)
//   rdata       head entry (valid while !empty)
//   full, empty occupancy flags, registered state only
module dec38_fifo2 #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == CNT_W'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/dec38_pipe.sv
// Registered 3-to-8 decoder with ready/valid on both sides.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    upstream handshake; in_ready = FIFO not full
//   in_code, in_none     encoded index; in_none forces an all-zero word
//   out_valid/out_ready  downstream handshake; out_valid = FIFO not empty
//   out_onehot           decode of the head entry, 0 when nothing buffered
//   seen, seen_clr       sticky OR of delivered words, synchronous clear
//   pop_cnt              count of delivered words, wraps modulo 256
module dec38_pipe #(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned CODE_W = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [CODE_W-1:0]      in_code,
  input  logic                   in_none,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2**CODE_W-1:0]   out_onehot,
  output logic [2**CODE_W-1:0]   seen,
  input  logic                   seen_clr,
  output logic [7:0]             pop_cnt
);

  import dec38_pkg::*;

  dec38_entry_t wentry;
  dec38_entry_t head;
  logic         full;
  logic         empty;
  logic         push;
  logic         pop;

  assign wentry = '{none: in_none, code: in_code};

  dec38_fifo2 #(
    .DEPTH (DEPTH),
    .W     ($bits(dec38_entry_t))
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (wentry),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Decoded straight from the registered head entry, so it stays put while
  // the word is stalled and has no path from the input side.
  always_comb begin
    out_onehot = '0;
    if (out_valid) out_onehot = dec38_onehot(head);
  end

  // Clear takes effect before the same-cycle pop contributes its bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen <= '0;
    end else if (seen_clr) begin
      seen <= pop ? out_onehot : '0;
    end else if (pop) begin
      seen <= seen | out_onehot;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pop_cnt <= '0;
    end else if (pop) begin
      pop_cnt <= pop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_dec38_pipe.sv
// Self-checking bench for dec38_pipe: constant vector table, hand-written
// corner sequences, and random traffic against a queue-based model.
module tb_dec38_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_code;
  logic       in_none;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_onehot;
  logic [7:0] seen;
  logic       seen_clr;
  logic [7:0] pop_cnt;

  always #5 clk = ~clk;

  dec38_pipe #(.DEPTH(2), .CODE_W(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_code    (in_code),
    .in_none    (in_none),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_onehot (out_onehot),
    .seen       (seen),
    .seen_clr   (seen_clr),
    .pop_cnt    (pop_cnt)
  );

  int n_pass  = 0;
  int n_total = 0;

  typedef struct packed {
    logic       none;
    logic [2:0] code;
  } ent_t;

  typedef struct {
    logic       none;
    logic [2:0] code;
    logic [7:0] exp;
  } vec_t;

  // Reference model: word queue, sticky mask, delivered-word counter.
  ent_t       q[$];
  logic [7:0] m_seen;
  logic [7:0] m_cnt;

  function automatic logic [7:0] ref_oh(input ent_t e);
    if (e.none) return 8'h00;
    return 8'(1 << e.code);
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
  endtask

  task automatic check_model();
    logic [7:0] exp_oh;
    exp_oh = 8'h00;
    if (q.size() > 0) exp_oh = ref_oh(q[0]);
    chk1("in_ready", in_ready, q.size() < 2);
    chk1("out_valid", out_valid, q.size() > 0);
    chk8("out_onehot", out_onehot, exp_oh);
    chk8("seen", seen, m_seen);
    chk8("pop_cnt", pop_cnt, m_cnt);
  endtask

  task automatic model_edge();
    logic       do_push;
    logic       do_pop;
    logic [7:0] oh;
    do_push = in_valid && (q.size() < 2);
    do_pop  = out_ready && (q.size() > 0);
    oh      = 8'h00;
    if (do_pop) oh = ref_oh(q[0]);
    if (seen_clr) m_seen = do_pop ? oh : 8'h00;
    else if (do_pop) m_seen = m_seen | oh;
    if (do_pop) begin
      void'(q.pop_front());
      m_cnt = m_cnt + 8'd1;
    end
    if (do_push) q.push_back({in_none, in_code});
  endtask

  task automatic model_reset();
    q.delete();
    m_seen = 8'h00;
    m_cnt  = 8'h00;
  endtask

  // One cycle: check at the falling edge, advance the model at the rising edge.
  task automatic tick();
    @(negedge clk);
    check_model();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Same as tick, with an explicit expected head word and valid flag.
  task automatic step_exp(input string name, input logic [7:0] exp_oh, input logic exp_v);
    @(negedge clk);
    chk8(name, out_onehot, exp_oh);
    chk1({name, "_valid"}, out_valid, exp_v);
    check_model();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  vec_t vec[9];

  initial begin
    vec = '{
      '{1'b0, 3'd0, 8'h01}, '{1'b0, 3'd1, 8'h02}, '{1'b0, 3'd2, 8'h04},
      '{1'b0, 3'd3, 8'h08}, '{1'b0, 3'd4, 8'h10}, '{1'b0, 3'd5, 8'h20},
      '{1'b0, 3'd6, 8'h40}, '{1'b0, 3'd7, 8'h80}, '{1'b1, 3'd5, 8'h00}
    };

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_code   = 3'd0;
    in_none   = 1'b0;
    out_ready = 1'b0;
    seen_clr  = 1'b0;
    model_reset();

    #12;
    chk1("rst_in_ready", in_ready, 1'b1);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk8("rst_out_onehot", out_onehot, 8'h00);
    chk8("rst_seen", seen, 8'h00);
    chk8("rst_pop_cnt", pop_cnt, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Sweep codes 0..7, each visible one cycle after its push.
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_none  = vec[i].none;
      in_code  = vec[i].code;
      tick();
      in_valid = 1'b0;
      step_exp("sweep_onehot", vec[i].exp, 1'b1);
    end
    @(negedge clk);
    chk8("sweep_pop_cnt", pop_cnt, 8'd8);
    chk8("sweep_seen", seen, 8'hFF);

    // in_none word: zero output, still counted, seen unchanged.
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_none  = vec[8].none;
    in_code  = vec[8].code;
    tick();
    in_valid = 1'b0;
    in_none  = 1'b0;
    step_exp("none_onehot", vec[8].exp, 1'b1);
    @(negedge clk);
    chk8("none_seen", seen, 8'hFF);
    chk8("none_pop_cnt", pop_cnt, 8'd9);
    @(posedge clk);
    #1;

    // Fill with downstream stalled: third push must be refused.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_code   = 3'd3;
    tick();
    in_code   = 3'd6;
    tick();
    in_code   = 3'd1;
    @(negedge clk);
    chk1("full_in_ready", in_ready, 1'b0);
    check_model();
    @(posedge clk);
    model_edge();
    #1;
    in_valid  = 1'b0;
    step_exp("stall_hold", 8'h08, 1'b1);
    out_ready = 1'b1;
    step_exp("drain_first", 8'h08, 1'b1);
    step_exp("drain_second", 8'h40, 1'b1);
    step_exp("drain_empty", 8'h00, 1'b0);

    // Clear with no pop, build seen = 0F, then clear while popping code 7.
    seen_clr = 1'b1;
    tick();
    seen_clr = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_code = 3'(i);
      tick();
    end
    in_code  = 3'd7;
    tick();
    in_valid = 1'b0;
    seen_clr = 1'b1;
    @(negedge clk);
    chk8("clr_pre_seen", seen, 8'h0F);
    chk8("clr_pre_head", out_onehot, 8'h80);
    check_model();
    @(posedge clk);
    model_edge();
    #1;
    seen_clr = 1'b0;
    @(negedge clk);
    chk8("clr_pop_seen", seen, 8'h80);
    @(posedge clk);
    #1;

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom % 4) != 0;
      in_code   = 3'($urandom_range(0, 7));
      in_none   = ($urandom % 8) == 0;
      out_ready = ($urandom % 3) != 0;
      seen_clr  = ($urandom % 16) == 0;
      tick();
    end
    seen_clr = 1'b0;
    in_none  = 1'b0;

    // Asynchronous reset with two entries buffered.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_code   = 3'd4;
    tick();
    out_ready = 1'b0;
    in_code   = 3'd2;
    tick();
    tick();
    in_valid  = 1'b0;
    @(negedge clk);
    chk1("pre_rst_full", in_ready, 1'b0);
    check_model();
    #2;
    rst_n = 1'b0;
    #1;
    chk1("arst_out_valid", out_valid, 1'b0);
    chk8("arst_out_onehot", out_onehot, 8'h00);
    chk8("arst_seen", seen, 8'h00);
    chk8("arst_pop_cnt", pop_cnt, 8'h00);
    chk1("arst_in_ready", in_ready, 1'b1);
    model_reset();
    @(posedge clk);
    #1;
    chk1("arst_hold_in_ready", in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 256 delivered words bring pop_cnt back to zero.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 256; i++) begin
      in_code = 3'(i % 8);
      tick();
    end
    in_valid = 1'b0;
    tick();
    @(negedge clk);
    chk8("wrap_pop_cnt", pop_cnt, 8'h00);
    chk8("wrap_seen", seen, 8'hFF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
